// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, centre sampling, LSB-first payload, one stop bit.
// Presents each good word with a one-cycle valid pulse, or a one-cycle framing-error pulse.
module uart_rx #(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_FREQ     = 10_000_000,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_serial_data,
    output logic [PAYLOAD_BITS-1:0] o_rx_data,
    output logic                    o_rx_valid,
    output logic                    o_frame_err,
    output logic                    o_rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW           = $clog2(PAYLOAD_BITS) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        BREAK_WAIT
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic                    rx_meta;
    logic                    rx_s;

    logic [CW-1:0]           clk_cnt;
    logic [CW-1:0]           clk_cnt_next;
    logic [BW-1:0]           bit_cnt;
    logic [BW-1:0]           bit_cnt_next;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS-1:0] shift_next;

    logic                    half_done;
    logic                    bit_done;
    logic                    valid_next;
    logic                    err_next;

    assign half_done = (clk_cnt == HALF_LAST);
    assign bit_done  = (clk_cnt == BIT_LAST);

    // The line idles high, so both stages reset high to avoid a false start after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_serial_data;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    next_state = START_BIT;
                end
            end
            START_BIT: begin
                if (half_done) begin
                    next_state = rx_s ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_done && (bit_cnt == DATA_LAST)) begin
                    next_state = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (bit_done) begin
                    next_state = rx_s ? IDLE : BREAK_WAIT;
                end
            end
            BREAK_WAIT: begin
                if (rx_s) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Leaving STOP_BIT at its mid-point gives the next start bit at least HALF_BIT of margin.
    always_comb begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        shift_next   = shift_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        unique case (state)
            IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
            end
            START_BIT: begin
                clk_cnt_next = half_done ? '0 : clk_cnt + 1'b1;
            end
            DATA_BITS: begin
                bit_cnt_next = bit_cnt;
                if (bit_done) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = bit_cnt + 1'b1;
                    shift_next   = {rx_s, shift_reg[PAYLOAD_BITS-1:1]};
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP_BIT: begin
                if (bit_done) begin
                    clk_cnt_next = '0;
                    valid_next   = rx_s;
                    err_next     = !rx_s;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            BREAK_WAIT: begin
                clk_cnt_next = '0;
            end
            default: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_rx_busy   <= 1'b0;
        end else begin
            clk_cnt     <= clk_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            o_rx_valid  <= valid_next;
            o_frame_err <= err_next;
            o_rx_busy   <= (state != IDLE);
            if (valid_next) begin
                o_rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=10: single frames, back-to-back stream,
// glitch rejection, framing error with break, mid-frame reset and bit-rate skew.
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int assertions = 0;
    int failures   = 0;

    int  valid_count = 0;
    int  err_count   = 0;
    int  both_count  = 0;
    logic [7:0] rx_log  [32];
    time        rx_time [32];

    uart_rx #(
        .BIT_RATE    (1_000_000),
        .CLK_FREQ    (10_000_000),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_serial_data(serial),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_frame_err  (frame_err),
        .o_rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (valid_count < 32) begin
                rx_log[valid_count]  = rx_data;
                rx_time[valid_count] = $time;
            end
            valid_count++;
        end
        if (frame_err) err_count++;
        if (rx_valid && frame_err) both_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame from a falling edge; bit k ends at cycle ((k+1)*num)/den,
    // so num/den is the bit period in clock cycles and may be fractional.
    task automatic applyStimulus(input logic [7:0] data, input logic stop,
                                 input int num, input int den);
        int t;
        int stop_at;
        t = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      serial = 1'b0;
            else if (k == 9) serial = stop;
            else             serial = data[k-1];
            stop_at = ((k + 1) * num) / den;
            repeat (stop_at - t) @(negedge clk);
            t = stop_at;
        end
    endtask

    initial begin
        int  base_v;
        int  base_e;
        time t0;
        int  lat;

        serial  = 1'b1;
        reset_n = 1'b0;
        idle(3);
        checkOutput("reset_data",  rx_data,   0);
        checkOutput("reset_valid", rx_valid,  0);
        checkOutput("reset_err",   frame_err, 0);
        checkOutput("reset_busy",  rx_busy,   0);
        reset_n = 1'b1;
        idle(10);

        // Single frame, with latency from the start edge to the valid sample.
        base_v = valid_count;
        base_e = err_count;
        t0 = $time;
        fork
            applyStimulus(8'hA5, 1'b1, 10, 1);
            begin
                idle(50);
                checkOutput("t1_busy_mid", rx_busy, 1);
            end
        join
        idle(20);
        checkOutput("t1_valid_count", valid_count - base_v, 1);
        checkOutput("t1_data", rx_log[base_v], 8'hA5);
        checkOutput("t1_err_count", err_count - base_e, 0);
        checkOutput("t1_busy_after", rx_busy, 0);
        lat = int'((rx_time[base_v] - t0) / 10);
        checkOutput("t1_latency_in_97_99", (lat >= 97 && lat <= 99), 1);

        // Back-to-back stream with no idle gap between stop and next start.
        base_v = valid_count;
        applyStimulus(8'h00, 1'b1, 10, 1);
        applyStimulus(8'hFF, 1'b1, 10, 1);
        applyStimulus(8'h55, 1'b1, 10, 1);
        applyStimulus(8'h3C, 1'b1, 10, 1);
        idle(20);
        checkOutput("t2_valid_count", valid_count - base_v, 4);
        checkOutput("t2_data0", rx_log[base_v],     8'h00);
        checkOutput("t2_data1", rx_log[base_v + 1], 8'hFF);
        checkOutput("t2_data2", rx_log[base_v + 2], 8'h55);
        checkOutput("t2_data3", rx_log[base_v + 3], 8'h3C);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2_period%0d", i),
                        32'(int'((rx_time[base_v + i + 1] - rx_time[base_v + i]) / 10)), 100);
        end

        // Short low glitch must be rejected at the start-bit mid-point.
        base_v = valid_count;
        base_e = err_count;
        serial = 1'b0;
        idle(3);
        serial = 1'b1;
        idle(30);
        checkOutput("t3_no_valid", valid_count - base_v, 0);
        checkOutput("t3_no_err", err_count - base_e, 0);
        checkOutput("t3_busy_idle", rx_busy, 0);
        checkOutput("t3_data_kept", rx_data, 8'h3C);
        applyStimulus(8'h81, 1'b1, 10, 1);
        idle(20);
        checkOutput("t3_next_frame", rx_log[base_v], 8'h81);
        checkOutput("t3_valid_count", valid_count - base_v, 1);

        // Bad stop bit followed by a held-low break.
        base_v = valid_count;
        base_e = err_count;
        applyStimulus(8'h12, 1'b0, 10, 1);
        idle(50);
        checkOutput("t4_busy_in_break", rx_busy, 1);
        serial = 1'b1;
        idle(20);
        checkOutput("t4_err_count", err_count - base_e, 1);
        checkOutput("t4_no_valid", valid_count - base_v, 0);
        checkOutput("t4_data_kept", rx_data, 8'h81);
        checkOutput("t4_busy_after", rx_busy, 0);
        applyStimulus(8'h34, 1'b1, 10, 1);
        idle(20);
        checkOutput("t4_next_frame", rx_log[base_v], 8'h34);
        checkOutput("t4_valid_count", valid_count - base_v, 1);

        // Reset after the fourth data bit of 0xF0 discards the partial frame.
        base_v = valid_count;
        base_e = err_count;
        serial = 1'b0;
        idle(50);
        checkOutput("t5_busy_before", rx_busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_data",  rx_data,   0);
        checkOutput("t5_rst_valid", rx_valid,  0);
        checkOutput("t5_rst_err",   frame_err, 0);
        checkOutput("t5_rst_busy",  rx_busy,   0);
        serial = 1'b1;
        idle(5);
        reset_n = 1'b1;
        idle(60);
        checkOutput("t5_no_pulse", valid_count - base_v, 0);
        checkOutput("t5_no_err", err_count - base_e, 0);
        applyStimulus(8'h0F, 1'b1, 10, 1);
        idle(20);
        checkOutput("t5_next_frame", rx_data, 8'h0F);
        checkOutput("t5_valid_count", valid_count - base_v, 1);

        // Bit-rate skew: periods of 9.7 and 10.4 cycles keep every centre sample
        // inside its bit for a HALF_BIT=5 start offset across all ten bits.
        base_v = valid_count;
        base_e = err_count;
        applyStimulus(8'h6B, 1'b1, 97, 10);
        idle(20);
        applyStimulus(8'h6B, 1'b1, 104, 10);
        idle(20);
        checkOutput("t6_valid_count", valid_count - base_v, 2);
        checkOutput("t6_fast_data", rx_log[base_v], 8'h6B);
        checkOutput("t6_slow_data", rx_log[base_v + 1], 8'h6B);
        checkOutput("t6_no_err", err_count - base_e, 0);

        checkOutput("valid_err_exclusive", both_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
